// File: rtl/ctrl_dbg.sv
// ctrl_dbg: CPU control FSM with HALT instruction, debug halt/single-step,
// memory-wait timeout with sticky fault and a retired-instruction counter.
package ctrl_dbg_pkg;
   localparam logic [1:0] MEM_NOP   = 2'd0;
   localparam logic [1:0] MEM_READ  = 2'd1;
   localparam logic [1:0] MEM_WRITE = 2'd2;
   localparam logic [2:0] AR_NOP    = 3'd0;
   localparam logic [2:0] AR_INC    = 3'd1;
   localparam logic       SEL_PC    = 1'b0;
   localparam logic       SEL_MAR   = 1'b1;
   localparam logic [3:0] ALU_THR   = 4'd0;
   localparam logic       REG_NOP   = 1'b0;
   localparam logic       REG_WRITE = 1'b1;
   localparam logic [1:0] REG_A     = 2'd0;
   localparam logic [1:0] MUX_ALU   = 2'd0;
   localparam logic [1:0] MUX_MEM   = 2'd1;

   typedef struct packed {
      logic [1:0] mem;
      logic [2:0] ar;
      logic       asel;
      logic [3:0] alu;
      logic       rop;
      logic [1:0] rin;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [1:0] mux;
   } ctl_t;

   localparam ctl_t CTL_IDLE = '{mem: MEM_NOP, ar: AR_NOP, asel: SEL_PC, alu: ALU_THR, rop: REG_NOP,
                                 rin: REG_A, rs1: REG_A, rs2: REG_A, mux: MUX_ALU};
endpackage

module ctrl_dbg
   import ctrl_dbg_pkg::*;
#(
   parameter int DATA_BUS_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic [1:0]                mem_ctrl_op,
   output logic [2:0]                addr_reg_op,
   output logic                      addr_sel,
   output logic [3:0]                alu_op,
   output logic                      reg_op,
   output logic [1:0]                reg_sel_in,
   output logic [1:0]                reg_sel_1,
   output logic [1:0]                reg_sel_2,
   output logic [1:0]                mux_sel,
   input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
   input  logic                      mem_op_done,
   input  logic                      flag_carry_in,
   input  logic                      flag_zero_in,
   input  logic                      dbg_halt_req,
   input  logic                      dbg_step,
   output logic                      halted,
   output logic                      fault,
   output logic [CNT_WIDTH-1:0]      retired_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      ST_FETCH, ST_DECODE, ST_ALU_OP, ST_LDX_RAM, ST_LDX_FLASH,
      ST_LDX_WRITE, ST_JMP_PARAM, ST_INC_PC, ST_HALT, ST_FAULT
   } state_e;

   state_e               state_q, state_d;
   ctl_t                 ctl_q, ctl_d;
   logic [5:0]           ir_q, ir_d;
   logic                 carry_q, carry_d, zero_q, zero_d;
   logic                 halt_instr_q, halt_instr_d, step_q, step_d, fault_q, fault_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [7:0]           b;
   logic                 taken;

   assign b     = bus_data_in[7:0];
   assign taken = (!b[5] | carry_q) & (!b[4] | zero_q);

   function automatic logic is_wait(state_e s);
      return s inside {ST_DECODE, ST_ALU_OP, ST_LDX_RAM, ST_LDX_FLASH, ST_LDX_WRITE, ST_JMP_PARAM};
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         ctl_q        <= CTL_IDLE;
         ir_q         <= '0;
         carry_q      <= 1'b0;
         zero_q       <= 1'b0;
         halt_instr_q <= 1'b0;
         step_q       <= 1'b0;
         fault_q      <= 1'b0;
         cnt_q        <= '0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         ctl_q        <= ctl_d;
         ir_q         <= ir_d;
         carry_q      <= carry_d;
         zero_q       <= zero_d;
         halt_instr_q <= halt_instr_d;
         step_q       <= step_d;
         fault_q      <= fault_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ir_d         = ir_q;
      carry_d      = carry_q;
      zero_d       = zero_q;
      halt_instr_d = halt_instr_q;
      step_d       = step_q;
      cnt_d        = cnt_q;
      tmo_d        = tmo_q;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE:
            if (mem_op_done) begin
               ir_d = b[5:0];
               case (b[7:6])
                  2'b00: begin
                     halt_instr_d = halt_instr_q | (b[5:4] == 2'b01);
                     state_d      = ST_INC_PC;
                  end
                  2'b01: state_d = ST_ALU_OP;
                  2'b10: state_d = b[5:4] == 2'b00 ? ST_LDX_RAM :
                                   b[5:4] == 2'b01 ? ST_LDX_WRITE :
                                   b[5:4] == 2'b10 ? ST_LDX_FLASH : ST_INC_PC;
                  default: state_d = taken ? ST_JMP_PARAM : ST_INC_PC;
               endcase
            end
         ST_ALU_OP:
            if (mem_op_done) begin
               carry_d = flag_carry_in;
               zero_d  = flag_zero_in;
               state_d = ST_INC_PC;
            end
         ST_LDX_RAM, ST_LDX_FLASH, ST_LDX_WRITE, ST_JMP_PARAM:
            if (mem_op_done) state_d = ST_INC_PC;
         ST_INC_PC: begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = (dbg_halt_req | halt_instr_q | step_q) ? ST_HALT : ST_FETCH;
         end
         ST_HALT:
            if (dbg_step) begin
               step_d  = 1'b1;
               state_d = ST_FETCH;
            end else if (!dbg_halt_req && !halt_instr_q) state_d = ST_FETCH;
         ST_FAULT: state_d = ST_FAULT;
         default: state_d = ST_FETCH;
      endcase
      // a done arriving on the limit cycle takes the normal path above
      if (is_wait(state_q) && !mem_op_done) begin
         tmo_d = tmo_q + TW'(1);
         if (tmo_d == TW'(TIMEOUT_CYCLES)) state_d = ST_FAULT;
      end
      if (is_wait(state_d) && state_d != state_q) tmo_d = '0;
      if (state_d == ST_HALT) step_d = 1'b0;
      fault_d = fault_q | (state_d == ST_FAULT);
   end

   always_comb begin
      ctl_d = CTL_IDLE;
      case (state_q)
         ST_FETCH: begin
            ctl_d.mem = MEM_READ;
            ctl_d.mux = MUX_MEM;
         end
         ST_DECODE:
            if (mem_op_done)
               case (b[7:6])
                  2'b01: begin
                     ctl_d.alu = b[5:2];
                     ctl_d.rs1 = b[1:0];
                     ctl_d.ar  = AR_INC;
                  end
                  2'b10:
                     case (b[5:4])
                        2'b00: begin
                           ctl_d.asel = SEL_MAR;
                           ctl_d.mem  = MEM_READ;
                        end
                        2'b01: begin
                           ctl_d.asel = SEL_MAR;
                           ctl_d.mem  = MEM_WRITE;
                           ctl_d.rs1  = b[3:2];
                        end
                        2'b10: begin
                           ctl_d.ar  = AR_INC;
                           ctl_d.mem = MEM_READ;
                        end
                        default: ;
                     endcase
                  2'b11: ctl_d.ar = AR_INC;
                  default: ;
               endcase
         ST_ALU_OP:
            if (mem_op_done) begin
               ctl_d.alu = ir_q[5:2];
               ctl_d.rs1 = ir_q[1:0];
               ctl_d.rs2 = b[7:6];
               ctl_d.rin = b[5:4];
               ctl_d.rop = REG_WRITE;
            end
         ST_LDX_RAM, ST_LDX_FLASH:
            if (mem_op_done) begin
               ctl_d.rop = REG_WRITE;
               ctl_d.rin = ir_q[3:2];
               ctl_d.mux = MUX_MEM;
            end
         ST_JMP_PARAM:
            if (mem_op_done) begin
               ctl_d.asel = ir_q[1];
               ctl_d.ar   = b[7:5];
               ctl_d.rs1  = ir_q[3:2];
            end
         ST_INC_PC: ctl_d.ar = AR_INC;
         default: ;
      endcase
   end

   assign mem_ctrl_op   = ctl_q.mem;
   assign addr_reg_op   = ctl_q.ar;
   assign addr_sel      = ctl_q.asel;
   assign alu_op        = ctl_q.alu;
   assign reg_op        = ctl_q.rop;
   assign reg_sel_in    = ctl_q.rin;
   assign reg_sel_1     = ctl_q.rs1;
   assign reg_sel_2     = ctl_q.rs2;
   assign mux_sel       = ctl_q.mux;
   assign halted        = state_q == ST_HALT;
   assign fault         = fault_q;
   assign retired_count = cnt_q;
endmodule

// File: tb/tb_ctrl_dbg.sv
// tb_ctrl_dbg: directed bench; expected write-back/jump/store events are queued
// by the stimulus and popped by an independent monitor.
module tb_ctrl_dbg;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mem_ctrl_op;
   logic [2:0]  addr_reg_op;
   logic        addr_sel;
   logic [3:0]  alu_op;
   logic        reg_op;
   logic [1:0]  reg_sel_in, reg_sel_1, reg_sel_2, mux_sel;
   logic [7:0]  bus_data_in = '0;
   logic        mem_op_done = 1'b0;
   logic        flag_carry_in = 1'b0, flag_zero_in = 1'b0;
   logic        dbg_halt_req = 1'b0, dbg_step = 1'b0;
   logic        halted, fault;
   logic [15:0] retired_count;
   int          tests = 0, fails = 0;
   logic [18:0] exp_q[$];
   logic [18:0] obs;

   always #5 clock = ~clock;

   ctrl_dbg #(.DATA_BUS_WIDTH(8), .TIMEOUT_CYCLES(4), .CNT_WIDTH(16)) dut (
      .clock(clock), .reset(reset), .mem_ctrl_op(mem_ctrl_op), .addr_reg_op(addr_reg_op),
      .addr_sel(addr_sel), .alu_op(alu_op), .reg_op(reg_op), .reg_sel_in(reg_sel_in),
      .reg_sel_1(reg_sel_1), .reg_sel_2(reg_sel_2), .mux_sel(mux_sel), .bus_data_in(bus_data_in),
      .mem_op_done(mem_op_done), .flag_carry_in(flag_carry_in), .flag_zero_in(flag_zero_in),
      .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step), .halted(halted), .fault(fault),
      .retired_count(retired_count));

   assign obs = {mem_ctrl_op, addr_reg_op, addr_sel, alu_op, reg_op, reg_sel_in, reg_sel_1, reg_sel_2, mux_sel};

   function automatic logic [18:0] ev(logic [1:0] mem, logic [2:0] ar, logic asel, logic [3:0] alu,
                                      logic rop, logic [1:0] rin, logic [1:0] rs1, logic [1:0] rs2,
                                      logic [1:0] mux);
      return {mem, ar, asel, alu, rop, rin, rs1, rs2, mux};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // register write, memory store or non-increment address op
   always @(negedge clock)
      if (!reset && (reg_op || mem_ctrl_op == 2'd2 || addr_reg_op > 3'd1)) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got %h with nothing queued", obs);
         end else chk("event", {13'd0, obs}, {13'd0, exp_q.pop_front()});
      end

   task automatic wait_fetch();
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (mem_ctrl_op == 2'd1 && mux_sel == 2'd1) return;
      end
      tests++;
      fails++;
      $display("FAIL fetch_timeout: no fetch within 40 cycles, required one");
   endtask

   task automatic wait_halted();
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (halted) return;
      end
      tests++;
      fails++;
      $display("FAIL halt_timeout: halted stayed 0 for 40 cycles, required 1");
   endtask

   task automatic feed(input logic [7:0] v, input int gap);
      repeat (gap) @(negedge clock);
      bus_data_in = v;
      mem_op_done = 1'b1;
      @(negedge clock);
      mem_op_done = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_ctl", {13'd0, obs}, 32'd0);
      chk("rst_cnt", {16'd0, retired_count}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      reset = 1'b0;
      wait_fetch();
      feed(8'h00, 0);
      wait_fetch();
      chk("cnt_nop", {16'd0, retired_count}, 32'd1);
      // ADD A,B -> C with flags 0/0
      exp_q.push_back(ev(2'd0, 3'd0, 1'b0, 4'd1, 1'b1, 2'd2, 2'd0, 2'd1, 2'd0));
      feed(8'h44, 0);
      feed(8'h60, 1);
      wait_fetch();
      chk("cnt_alu", {16'd0, retired_count}, 32'd2);
      // carry-conditional jump with carry clear: no param fetch
      feed(8'hE0, 0);
      wait_fetch();
      chk("cnt_jmp_nt", {16'd0, retired_count}, 32'd3);
      flag_carry_in = 1'b1;
      flag_zero_in  = 1'b1;
      exp_q.push_back(ev(2'd0, 3'd0, 1'b0, 4'd2, 1'b1, 2'd0, 2'd3, 2'd2, 2'd0));
      feed(8'h4B, 0);
      feed(8'h80, 2);
      flag_carry_in = 1'b0;
      flag_zero_in  = 1'b0;
      wait_fetch();
      chk("cnt_alu2", {16'd0, retired_count}, 32'd4);
      exp_q.push_back(ev(2'd0, 3'd5, 1'b1, 4'd0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0));
      feed(8'hE6, 0);
      feed(8'hA0, 1);
      wait_fetch();
      chk("cnt_jmp_c", {16'd0, retired_count}, 32'd5);
      exp_q.push_back(ev(2'd0, 3'd3, 1'b0, 4'd0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0));
      feed(8'hD8, 0);
      feed(8'h60, 0);
      wait_fetch();
      chk("cnt_jmp_z", {16'd0, retired_count}, 32'd6);
      // halt request raised while the RAM load is waiting
      feed(8'h8C, 0);
      dbg_halt_req = 1'b1;
      exp_q.push_back(ev(2'd0, 3'd0, 1'b0, 4'd0, 1'b1, 2'd3, 2'd0, 2'd0, 2'd1));
      feed(8'h5A, 2);
      wait_halted();
      repeat (3) @(negedge clock);
      chk("halt_req_halted", {31'd0, halted}, 32'd1);
      chk("halt_req_cnt", {16'd0, retired_count}, 32'd7);
      dbg_halt_req = 1'b0;
      wait_fetch();
      chk("resume_halted", {31'd0, halted}, 32'd0);
      exp_q.push_back(ev(2'd2, 3'd0, 1'b1, 4'd0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0));
      feed(8'h98, 0);
      feed(8'h00, 3);
      wait_fetch();
      chk("cnt_ldx_wr", {16'd0, retired_count}, 32'd8);
      chk("no_fault_limit", {31'd0, fault}, 32'd0);
      exp_q.push_back(ev(2'd0, 3'd0, 1'b0, 4'd0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd1));
      feed(8'hA4, 0);
      feed(8'h33, 1);
      wait_fetch();
      chk("cnt_flash", {16'd0, retired_count}, 32'd9);
      // reset while the ALU instruction waits for its second byte
      feed(8'h44, 0);
      reset = 1'b1;
      #1;
      chk("midrst_ctl", {13'd0, obs}, 32'd0);
      chk("midrst_cnt", {16'd0, retired_count}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      wait_fetch();
      feed(8'h10, 0);
      wait_halted();
      chk("halt_instr_cnt", {16'd0, retired_count}, 32'd1);
      repeat (5) @(negedge clock);
      chk("halt_sticky", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         dbg_step = 1'b1;
         @(negedge clock);
         dbg_step = 1'b0;
         wait_fetch();
         feed(8'h00, 0);
         wait_halted();
         chk("step_cnt", {16'd0, retired_count}, 32'(i + 2));
      end
      repeat (5) @(negedge clock);
      chk("step_final_cnt", {16'd0, retired_count}, 32'd4);
      chk("step_final_halted", {31'd0, halted}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      wait_fetch();
      chk("tmo_start", {31'd0, fault}, 32'd0);
      repeat (3) @(negedge clock);
      chk("tmo_3", {31'd0, fault}, 32'd0);
      @(negedge clock);
      chk("tmo_4", {31'd0, fault}, 32'd1);
      feed(8'h00, 0);
      repeat (5) @(negedge clock);
      chk("fault_sticky", {31'd0, fault}, 32'd1);
      chk("fault_ctl", {13'd0, obs}, 32'd0);
      chk("fault_cnt", {16'd0, retired_count}, 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
